// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes shared with the decoder and the execute-unit FSM state type.
package alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  typedef enum logic {S_IDLE = 1'b0, S_MUL_RUN = 1'b1} state_e;
endpackage

// File: rtl/alu_iter_mul.sv
// alu_iter_mul: iterative shift-add multiplier, one multiplier bit per cycle, low WIDTH product bits.
module alu_iter_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_kill,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, w_acc_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_busy;
  // done and product are presented during the final iteration so the caller can register them on that edge
  always_comb w_acc_next = r_mplier[0] ? r_acc + r_mcand : r_acc;
  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == LAST);
  assign o_product = w_acc_next;
  always_ff @(posedge clk) begin
    if (rst || i_kill) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start && !r_busy) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      r_busy   <= !o_done;
    end
  end
endmodule

// File: rtl/alu_execute_unit.sv
// alu_execute_unit: EX-stage ALU; single-cycle add/sub/and/sll/slt plus a stalling iterative mul.
module alu_execute_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [3:0]       alu_control_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic [4:0]       rd_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic [4:0]       rd_o,
  output logic             valid_o,
  output logic             stall_o
);
  state_e r_state, w_state_next;
  logic w_accept, w_is_mul, w_mul_start, w_single, w_mul_busy, w_mul_done, w_done, w_load;
  logic [WIDTH-1:0] w_alu_res, w_mul_prod, w_load_val, w_slt, r_result;
  logic [4:0] r_rd, r_rd_lat;
  logic r_zero, r_valid;
  assign w_accept    = valid_i && !stall_o && !flush_i;
  assign w_is_mul    = alu_control_i == ALU_MUL;
  assign w_mul_start = w_accept && w_is_mul;
  assign w_single    = w_accept && !w_is_mul;
  assign w_done      = w_mul_busy && w_mul_done && !flush_i;
  assign w_load      = w_single || w_done;
  assign w_slt       = {{(WIDTH-1){1'b0}}, $signed(src_a_i) < $signed(src_b_i)};
  // unlisted codes fall through to add
  always_comb
    w_alu_res = (alu_control_i == ALU_SUB) ? src_a_i - src_b_i :
                (alu_control_i == ALU_AND) ? src_a_i & src_b_i :
                (alu_control_i == ALU_SLL) ? src_a_i << src_b_i[SHAMT_W-1:0] :
                (alu_control_i == ALU_SLT) ? w_slt :
                src_a_i + src_b_i;
  assign w_load_val = w_done ? w_mul_prod : w_alu_res;
  alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_kill    (flush_i),
    .i_a       (src_a_i),
    .i_b       (src_b_i),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_state_next;
  always_comb
    w_state_next = flush_i ? S_IDLE :
                   (r_state == S_IDLE) ? (w_mul_start ? S_MUL_RUN : S_IDLE) :
                   (w_mul_done ? S_IDLE : S_MUL_RUN);
  always_comb stall_o = r_state == S_MUL_RUN;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_rd     <= '0;
      r_valid  <= 1'b0;
      r_rd_lat <= '0;
    end else begin
      r_valid <= w_load;
      if (w_mul_start) r_rd_lat <= rd_i;
      if (w_load) begin
        r_result <= w_load_val;
        r_zero   <= w_load_val == '0;
        r_rd     <= w_done ? r_rd_lat : rd_i;
      end
    end
  end
  assign result_o = r_result;
  assign zero_o   = r_zero;
  assign rd_o     = r_rd;
  assign valid_o  = r_valid;
endmodule

// File: tb/tb_alu_execute_unit.sv
// tb_alu_execute_unit: directed stimulus with a result scoreboard drained on each valid_o pulse.
module tb_alu_execute_unit;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst, valid_i, flush_i, zero_o, valid_o, stall_o;
  logic [3:0] alu_control_i;
  logic [W-1:0] src_a_i, src_b_i, result_o;
  logic [4:0] rd_i, rd_o;
  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
    logic         zero;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int errs = 0;
  always #5 clk = ~clk;
  alu_execute_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .alu_control_i(alu_control_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .rd_i(rd_i), .flush_i(flush_i),
    .result_o(result_o), .zero_o(zero_o), .rd_o(rd_o), .valid_o(valid_o), .stall_o(stall_o)
  );
  function automatic logic [W-1:0] model(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
    case (c)
      4'b0001: return a - b;
      4'b0010: return a * b;
      4'b0011: return a & b;
      4'b0110: return a << b[4:0];
      4'b1000: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction
  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && valid_o === 1'b1) begin
      if (q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("result", result_o, e.res);
        check("rd", {27'd0, rd_o}, {27'd0, e.rd});
        check("zero", {31'd0, zero_o}, {31'd0, e.zero});
      end
    end
  end
  task automatic issue(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b, logic [4:0] t, bit push);
    logic [W-1:0] r;
    @(negedge clk);
    if (push && c != 4'b0010) check("no_stall_at_issue", {31'd0, stall_o}, 32'd0);
    valid_i = 1'b1; alu_control_i = c; src_a_i = a; src_b_i = b; rd_i = t;
    r = model(c, a, b);
    if (push) q.push_back('{r, t, r == '0});
  endtask
  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
  endtask
  task automatic drain(int bound);
    int k;
    for (k = 0; k < bound && q.size() != 0; k++) idle(1);
    if (q.size() != 0) check("drain_timeout", q.size(), 32'd0);
  endtask
  initial begin
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; alu_control_i = '0;
    src_a_i = '0; src_b_i = '0; rd_i = '0;
    repeat (2) @(negedge clk);
    check("rst_result", result_o, 32'd0);
    check("rst_outs", {27'd0, rd_o, zero_o, valid_o, stall_o}, 32'd0);
    rst = 1'b0;
    issue(4'b0000, 32'd7, 32'd5, 5'd3, 1);
    idle(1);
    check("add_valid_hi", {31'd0, valid_o}, 32'd1);
    idle(1);
    check("add_valid_pulse", {31'd0, valid_o}, 32'd0);
    issue(4'b0001, 32'd5, 32'd5, 5'd1, 1);
    issue(4'b1000, 32'hFFFF_FFFF, 32'd1, 5'd2, 1);
    issue(4'b1000, 32'd1, 32'hFFFF_FFFF, 5'd4, 1);
    issue(4'b0110, 32'd1, 32'h25, 5'd5, 1);
    issue(4'b0011, 32'hF0F0, 32'h0FF0, 5'd8, 1);
    issue(4'b0101, 32'd2, 32'd3, 5'd10, 1);
    drain(5);
    issue(4'b0010, 32'hFFFF_FFFF, 32'd3, 5'd7, 1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("mul_stall_hi", {31'd0, stall_o}, 32'd1);
      check("mul_no_early_valid", {31'd0, valid_o}, 32'd0);
      valid_i = (i % 2 == 0); alu_control_i = 4'b0000; src_a_i = 32'd1; src_b_i = 32'd1; rd_i = 5'd31;
    end
    @(negedge clk);
    valid_i = 1'b0;
    check("mul_stall_lo", {31'd0, stall_o}, 32'd0);
    check("mul_valid", {31'd0, valid_o}, 32'd1);
    drain(3);
    issue(4'b0010, 32'h10000, 32'h10000, 5'd9, 1);
    drain(40);
    issue(4'b0010, 32'd1234, 32'd5678, 5'd12, 0);
    idle(9);
    @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b1; alu_control_i = 4'b0000; src_a_i = 32'd1; src_b_i = 32'd1; rd_i = 5'd13;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_stall_lo", {31'd0, stall_o}, 32'd0);
    check("flush_no_valid", {31'd0, valid_o}, 32'd0);
    check("flush_hold_result", result_o, 32'd0);
    check("flush_hold_rd", {27'd0, rd_o}, 32'd9);
    valid_i = 1'b1; alu_control_i = 4'b0000; src_a_i = 32'd20; src_b_i = 32'd22; rd_i = 5'd6;
    q.push_back('{32'd42, 5'd6, 1'b0});
    drain(3);
    issue(4'b0010, 32'd3, 32'd4, 5'd2, 0);
    idle(5);
    @(negedge clk);
    rst = 1'b1; flush_i = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    check("midmul_rst_result", result_o, 32'd0);
    check("midmul_rst_outs", {27'd0, rd_o, zero_o, valid_o, stall_o}, 32'd0);
    rst = 1'b0; flush_i = 1'b0;
    issue(4'b0000, 32'd100, 32'hFFFF_FFFF, 5'd1, 1);
    drain(3);
    idle(2);
    check("queue_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
